// File: rtl/sequence_generator.sv
// Game sequence generator: fills a DEPTH-entry digit RAM from a free-running LFSR on a GoGen
// rising edge and serves 2-cycle reads. Define SEQGEN_NO_REPEAT_EN to forbid equal neighbours.
module sequence_generator #(
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DIGIT_W = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               GoGen,
    input  logic [1:0]         Diff,
    input  logic [ADDR_W-1:0]  SeqAddr,
    output logic [DIGIT_W-1:0] RAMOutput,
    output logic               FinGen,
    output logic               Busy
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StFill = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e              state_q;
    logic [15:0]         lfsr_q;
    logic                lfsr_fb;
    logic                go_q;
    logic                start;
    logic [ADDR_W-1:0]   wptr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          diff_q;
    logic [DIGIT_W-1:0]  ram_out_q;
    logic                fin_gen_q;
    logic                busy_q;
    logic [3:0]          rnd;
    logic [3:0]          digit_raw;
    logic [3:0]          digit_wr;
    logic [DIGIT_W-1:0]  mem_q [DEPTH];

    assign rnd     = lfsr_q[3:0];
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign start   = GoGen & ~go_q;

    // Difficulty 00 is treated like 01.
    always_comb begin
        digit_raw = 4'd1;
        case (diff_q)
            2'b10:   digit_raw = {1'b0, rnd[2:0]} + 4'd1;
            2'b11:   digit_raw = ((rnd >= 4'd9) ? (rnd - 4'd9) : rnd) + 4'd1;
            default: digit_raw = {2'b00, rnd[1:0]} + 4'd1;
        endcase
    end

`ifdef SEQGEN_NO_REPEAT_EN
    logic [3:0] prev_q;
    logic [3:0] digit_max;

    always_comb begin
        digit_max = 4'd4;
        case (diff_q)
            2'b10:   digit_max = 4'd8;
            2'b11:   digit_max = 4'd9;
            default: digit_max = 4'd4;
        endcase
    end

    // A repeat is bumped to the next value, wrapping max back to 1.
    always_comb begin
        digit_wr = digit_raw;
        if (digit_raw == prev_q) begin
            digit_wr = (digit_raw == digit_max) ? 4'd1 : digit_raw + 4'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            prev_q <= 4'd0;
        end else if (state_q == StIdle && start) begin
            prev_q <= 4'd0;
        end else if (state_q == StFill) begin
            prev_q <= digit_wr;
        end
    end
`else
    assign digit_wr = digit_raw;
`endif

    // Storage is never reset; a reset mid-fill leaves it partially written.
    always_ff @(posedge Clk) begin
        if (Rst && state_q == StFill) begin
            mem_q[wptr_q] <= DIGIT_W'(digit_wr);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q   <= StIdle;
            lfsr_q    <= SEED;
            wptr_q    <= '0;
            go_q      <= 1'b0;
            addr_q    <= '0;
            diff_q    <= 2'b00;
            ram_out_q <= '0;
            fin_gen_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            go_q      <= GoGen;
            addr_q    <= SeqAddr;
            ram_out_q <= mem_q[addr_q];
            lfsr_q    <= (lfsr_q == 16'd0) ? SEED : {lfsr_q[14:0], lfsr_fb};
            fin_gen_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        diff_q  <= Diff;
                        wptr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StFill;
                    end
                end
                StFill: begin
                    if (wptr_q == LastAddr) begin
                        wptr_q    <= '0;
                        busy_q    <= 1'b0;
                        fin_gen_q <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        wptr_q <= wptr_q + ADDR_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    fin_gen_q <= 1'b0;
                    ram_out_q <= '0;
                end
            endcase
        end
    end

    assign RAMOutput = ram_out_q;
    assign FinGen    = fin_gen_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: reset, fill timing, digit ranges, read latency,
// GoGen handshake and reset abort, with an LFSR/digit reference model.
module tb_sequence_generator;

    logic       Clk;
    logic       Rst;
    logic       GoGen;
    logic [1:0] Diff;
    logic [4:0] SeqAddr;
    logic [3:0] RAMOutput;
    logic       FinGen;
    logic       Busy;

    int n_tests;
    int n_fail;

    logic [15:0] tb_lfsr;
    logic [3:0]  exp_mem [32];
    int          busy_cnt, busy_first, busy_last, fin_cnt, fin_pos;
    logic        busy_pre, busy_at_fin;

    sequence_generator dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .GoGen     (GoGen),
        .Diff      (Diff),
        .SeqAddr   (SeqAddr),
        .RAMOutput (RAMOutput),
        .FinGen    (FinGen),
        .Busy      (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference LFSR, x^16+x^14+x^13+x^11+1, free-running while out of reset.
    always @(posedge Clk) begin
        if (!Rst || tb_lfsr == 16'd0) tb_lfsr <= 16'hACE1;
        else tb_lfsr <= {tb_lfsr[14:0], tb_lfsr[15] ^ tb_lfsr[13] ^ tb_lfsr[12] ^ tb_lfsr[10]};
    end

    function automatic logic [3:0] model_digit(input logic [15:0] l, input logic [1:0] d);
        int r;
        r = int'(l[3:0]);
        case (d)
            2'b10:   return 4'((r % 8) + 1);
            2'b11:   return 4'((r % 9) + 1);
            default: return 4'((r % 4) + 1);
        endcase
    endfunction

    // Raises GoGen, records Busy/FinGen activity over 40 cycles and builds the expected RAM.
    task automatic do_fill(input logic [1:0] diff, input int glitch_at, input int chg_at,
                           input logic [1:0] chg_diff);
        logic [3:0] d;
`ifdef SEQGEN_NO_REPEAT_EN
        logic [3:0] prev;
        logic [3:0] dmax;
        prev = 4'd0;
        dmax = (diff == 2'b10) ? 4'd8 : (diff == 2'b11) ? 4'd9 : 4'd4;
`endif
        @(posedge Clk); #1;
        Diff  = diff;
        GoGen = 1'b1;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        fin_cnt = 0; fin_pos = -1; busy_at_fin = 1'b0;
        @(negedge Clk);
        busy_pre = Busy;
        for (int j = 1; j <= 40; j++) begin
            @(negedge Clk);
            if (j <= 32) begin
                d = model_digit(tb_lfsr, diff);
`ifdef SEQGEN_NO_REPEAT_EN
                if (d == prev) d = (d == dmax) ? 4'd1 : d + 4'd1;
                prev = d;
`endif
                exp_mem[j-1] = d;
            end
            if (Busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = j;
                busy_last = j;
            end
            if (FinGen) begin
                fin_cnt++;
                fin_pos = j;
                busy_at_fin = Busy;
            end
            if (glitch_at > 0 && j == glitch_at) GoGen = 1'b0;
            if (glitch_at > 0 && j == glitch_at + 1) GoGen = 1'b1;
            if (chg_at > 0 && j == chg_at) Diff = chg_diff;
        end
    endtask

    task automatic read_addr(input logic [4:0] a, output logic [3:0] data);
        @(posedge Clk); #1;
        SeqAddr = a;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        data = RAMOutput;
    endtask

    task automatic test_reset;
        int busy_seen, fin_seen;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_tests++;
        if (RAMOutput !== 4'd0) begin
            n_fail++; $display("FAIL reset_ramoutput: got %0d expected 0", RAMOutput);
        end
        n_tests++;
        if (FinGen !== 1'b0) begin
            n_fail++; $display("FAIL reset_fingen: got %b expected 0", FinGen);
        end
        n_tests++;
        if (Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy);
        end
        @(posedge Clk); #1;
        Rst = 1'b1;
        busy_seen = 0; fin_seen = 0;
        repeat (100) begin
            @(negedge Clk);
            if (Busy !== 1'b0) busy_seen++;
            if (FinGen !== 1'b0) fin_seen++;
        end
        n_tests++;
        if (busy_seen != 0) begin
            n_fail++; $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_seen);
        end
        n_tests++;
        if (fin_seen != 0) begin
            n_fail++; $display("FAIL idle_fingen: got %0d pulses expected 0", fin_seen);
        end
    endtask

    task automatic test_fill_timing;
        logic [3:0] data;
        do_fill(2'b01, 0, 0, 2'b01);
        @(posedge Clk); #1;
        GoGen = 1'b0;
        n_tests++;
        if (busy_pre !== 1'b0) begin
            n_fail++; $display("FAIL t2_busy_pre: got %b expected 0", busy_pre);
        end
        n_tests++;
        if (busy_first != 1 || busy_last != 32 || busy_cnt != 32) begin
            n_fail++;
            $display("FAIL t2_busy_window: got first=%0d last=%0d count=%0d expected 1 32 32",
                     busy_first, busy_last, busy_cnt);
        end
        n_tests++;
        if (fin_cnt != 1 || fin_pos != 33) begin
            n_fail++;
            $display("FAIL t2_fingen: got count=%0d pos=%0d expected 1 33", fin_cnt, fin_pos);
        end
        n_tests++;
        if (busy_at_fin !== 1'b0) begin
            n_fail++; $display("FAIL t2_busy_at_fin: got %b expected 0", busy_at_fin);
        end
        for (int i = 0; i < 32; i++) begin
            read_addr(5'(i), data);
            n_tests++;
            if (data !== exp_mem[i] || data < 4'd1 || data > 4'd4) begin
                n_fail++;
                $display("FAIL t2_data[%0d]: got %0d expected %0d (range 1..4)",
                         i, data, exp_mem[i]);
            end
        end
    endtask

    task automatic test_ranges;
        logic [1:0] d;
        logic [3:0] dmax;
        logic [3:0] data;
        for (int t = 0; t < 3; t++) begin
            case (t)
                0:       begin d = 2'b10; dmax = 4'd8; end
                1:       begin d = 2'b11; dmax = 4'd9; end
                default: begin d = 2'b00; dmax = 4'd4; end
            endcase
            do_fill(d, 0, 0, d);
            @(posedge Clk); #1;
            GoGen = 1'b0;
            n_tests++;
            if (fin_cnt != 1 || fin_pos != 33) begin
                n_fail++;
                $display("FAIL t3_fingen diff=%b: got count=%0d pos=%0d expected 1 33",
                         d, fin_cnt, fin_pos);
            end
            for (int i = 0; i < 32; i++) begin
                read_addr(5'(i), data);
                n_tests++;
                if (data !== exp_mem[i] || data < 4'd1 || data > dmax) begin
                    n_fail++;
                    $display("FAIL t3_data diff=%b [%0d]: got %0d expected %0d (max %0d)",
                             d, i, data, exp_mem[i], dmax);
                end
            end
        end
    endtask

    // Relies on the previous fill and on SeqAddr having been left at 31.
    task automatic test_read_latency;
        @(posedge Clk); #1;
        SeqAddr = 5'd5;
        @(posedge Clk); #1;
        SeqAddr = 5'd6;
        @(negedge Clk);
        n_tests++;
        if (RAMOutput !== exp_mem[31]) begin
            n_fail++; $display("FAIL t4_after_e1: got %0d expected %0d", RAMOutput, exp_mem[31]);
        end
        @(negedge Clk);
        n_tests++;
        if (RAMOutput !== exp_mem[5]) begin
            n_fail++; $display("FAIL t4_after_e2: got %0d expected %0d", RAMOutput, exp_mem[5]);
        end
        @(negedge Clk);
        n_tests++;
        if (RAMOutput !== exp_mem[6]) begin
            n_fail++; $display("FAIL t4_after_e3: got %0d expected %0d", RAMOutput, exp_mem[6]);
        end
    endtask

    task automatic test_handshake;
        int extra;
        logic [3:0] data;
        do_fill(2'b10, 10, 12, 2'b11);
        extra = 0;
        repeat (160) begin
            @(negedge Clk);
            if (FinGen) extra++;
        end
        @(posedge Clk); #1;
        GoGen = 1'b0;
        Diff  = 2'b01;
        n_tests++;
        if (fin_cnt + extra != 1 || fin_pos != 33) begin
            n_fail++;
            $display("FAIL t5_single_fin: got count=%0d pos=%0d expected 1 33",
                     fin_cnt + extra, fin_pos);
        end
        for (int i = 0; i < 32; i++) begin
            read_addr(5'(i), data);
            n_tests++;
            if (data !== exp_mem[i] || data < 4'd1 || data > 4'd8) begin
                n_fail++;
                $display("FAIL t5_latched_diff[%0d]: got %0d expected %0d", i, data, exp_mem[i]);
            end
        end
    endtask

    task automatic test_reset_abort;
        int fin_seen, busy_seen;
        logic [3:0] data;
        logic [3:0] rd [32];
        @(posedge Clk); #1;
        Diff  = 2'b01;
        GoGen = 1'b1;
        repeat (11) @(posedge Clk);
        #1;
        Rst   = 1'b0;
        GoGen = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        n_tests++;
        if (Busy !== 1'b0 || FinGen !== 1'b0 || RAMOutput !== 4'd0) begin
            n_fail++;
            $display("FAIL t6_abort_outputs: got busy=%b fin=%b ram=%0d expected 0 0 0",
                     Busy, FinGen, RAMOutput);
        end
        @(posedge Clk); #1;
        Rst = 1'b1;
        fin_seen = 0; busy_seen = 0;
        repeat (50) begin
            @(negedge Clk);
            if (FinGen !== 1'b0) fin_seen++;
            if (Busy !== 1'b0) busy_seen++;
        end
        n_tests++;
        if (fin_seen != 0 || busy_seen != 0) begin
            n_fail++;
            $display("FAIL t6_no_fin_after_abort: got fin=%0d busy=%0d expected 0 0",
                     fin_seen, busy_seen);
        end
        do_fill(2'b01, 0, 0, 2'b01);
        @(posedge Clk); #1;
        GoGen = 1'b0;
        n_tests++;
        if (fin_cnt != 1 || fin_pos != 33) begin
            n_fail++;
            $display("FAIL t6_restart_fin: got count=%0d pos=%0d expected 1 33", fin_cnt, fin_pos);
        end
        for (int i = 0; i < 32; i++) begin
            read_addr(5'(i), data);
            rd[i] = data;
            n_tests++;
            if (data !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL t6_data[%0d]: got %0d expected %0d", i, data, exp_mem[i]);
            end
        end
`ifdef SEQGEN_NO_REPEAT_EN
        for (int i = 0; i < 31; i++) begin
            n_tests++;
            if (rd[i] === rd[i+1]) begin
                n_fail++;
                $display("FAIL t6_no_repeat[%0d]: got %0d twice expected different", i, rd[i]);
            end
        end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        Rst     = 1'b0;
        GoGen   = 1'b0;
        Diff    = 2'b01;
        SeqAddr = 5'd0;
        test_reset();
        test_fill_timing();
        test_ranges();
        test_read_latency();
        test_handshake();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
